// File: rtl/fft_input_loader_if.sv
// Sample-stream and frame/FFT-core handshake bundle for fft_input_loader.
// master = upstream source plus FFT core side, slave = the loader itself.
interface fft_input_loader_if #(
  parameter int formatWidth = 9,
  parameter int POINTS      = 32
);
  logic [10:0]                   fft_size;
  logic                          in_valid;
  logic                          in_ready;
  logic [formatWidth-1:0]        in_real;
  logic [formatWidth-1:0]        in_imag;
  logic [formatWidth*POINTS-1:0] input_real;
  logic [formatWidth*POINTS-1:0] input_imag;
  logic                          fft_start;
  logic                          fft_done;
  logic                          busy;
  logic                          size_err;

  modport master (
    output fft_size, in_valid, in_real, in_imag, fft_done,
    input  in_ready, input_real, input_imag, fft_start, busy, size_err
  );

  modport slave (
    input  fft_size, in_valid, in_real, in_imag, fft_done,
    output in_ready, input_real, input_imag, fft_start, busy, size_err
  );
endinterface

// File: rtl/fft_input_loader.sv
// Collects N complex custom-float samples into a parallel frame and hands it to the FFT core.
// Define BIT_REVERSE_EN to store samples at bit-reversed lane addresses.
module fft_input_loader #(
  parameter int formatWidth = 9,
  parameter int POINTS      = 32
) (
  input logic               clk,
  input logic               rst,
  fft_input_loader_if.slave bus
);

  localparam int CNT_W = $clog2(POINTS + 1);
  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(POINTS);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, FILL, START, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       size_q,  size_d;
  logic                   err_q,   err_d;
  logic                   fft_start_q, fft_start_d;
  logic                   busy_q,  busy_d;
  logic [formatWidth-1:0] re_q [POINTS];
  logic [formatWidth-1:0] re_d [POINTS];
  logic [formatWidth-1:0] im_q [POINTS];
  logic [formatWidth-1:0] im_d [POINTS];

  logic                   in_ready;
  logic                   hs;
  logic                   legal;
  logic [CNT_W-1:0]       wr_addr;

  function automatic logic size_legal(input logic [10:0] sz);
    case (sz)
      11'd4, 11'd8, 11'd16, 11'd32: size_legal = (int'(sz) <= POINTS);
      default:                      size_legal = 1'b0;
    endcase
  endfunction

`ifdef BIT_REVERSE_EN
  localparam int LOG_P = $clog2(POINTS);

  // Reverse over the full lane width, then drop the bits a shorter frame does not use.
  function automatic logic [CNT_W-1:0] bit_rev(input logic [CNT_W-1:0] cnt,
                                               input logic [CNT_W-1:0] n);
    logic [LOG_P-1:0] full;
    int               bits;
    bits = 0;
    for (int b = 0; b < CNT_W; b++) begin
      if (n[b]) bits = b;
    end
    for (int i = 0; i < LOG_P; i++) begin
      full[LOG_P-1-i] = cnt[i];
    end
    return CNT_W'(full >> (LOG_P - bits));
  endfunction
`endif

  // Reset gates readiness so no sample can slip in while the frame is being discarded.
  assign in_ready = ((state_q == IDLE) || (state_q == FILL)) && !rst;
  assign hs       = bus.in_valid && in_ready;
  assign legal    = size_legal(bus.fft_size);

  always_comb begin
`ifdef BIT_REVERSE_EN
    wr_addr = bit_rev(count_q, size_q);
`else
    wr_addr = count_q;
`endif
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    size_d  = size_q;
    err_d   = err_q;
    re_d    = re_q;
    im_d    = im_q;

    case (state_q)
      IDLE: begin
        if (hs) begin
          size_d  = legal ? bus.fft_size[CNT_W-1:0] : N_MAX;
          err_d   = err_q | !legal;
          count_d = ONE;
          for (int k = 0; k < POINTS; k++) begin
            if (k == 0) begin
              re_d[k] = bus.in_real;
              im_d[k] = bus.in_imag;
            end else if (k >= int'(size_d)) begin
              re_d[k] = '0;
              im_d[k] = '0;
            end
          end
          state_d = (size_d == ONE) ? START : FILL;
        end
      end
      FILL: begin
        if (hs) begin
          for (int k = 0; k < POINTS; k++) begin
            if (k == int'(wr_addr)) begin
              re_d[k] = bus.in_real;
              im_d[k] = bus.in_imag;
            end
          end
          count_d = count_q + ONE;
          if (count_q == size_q - ONE) state_d = START;
        end
      end
      START: state_d = BUSY;
      BUSY: begin
        if (bus.fft_done) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    fft_start_d = (state_d == START);
    busy_d      = (state_d == BUSY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      size_q      <= '0;
      err_q       <= 1'b0;
      fft_start_q <= 1'b0;
      busy_q      <= 1'b0;
      // NOTE: the lane array is cleared on reset because its contents are visible on the outputs.
      for (int k = 0; k < POINTS; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      size_q      <= size_d;
      err_q       <= err_d;
      fft_start_q <= fft_start_d;
      busy_q      <= busy_d;
      re_q        <= re_d;
      im_q        <= im_d;
    end
  end

  for (genvar k = 0; k < POINTS; k++) begin : g_lane
    assign bus.input_real[k*formatWidth +: formatWidth] = re_q[k];
    assign bus.input_imag[k*formatWidth +: formatWidth] = im_q[k];
  end

  assign bus.in_ready  = in_ready;
  assign bus.fft_start = fft_start_q;
  assign bus.busy      = busy_q;
  assign bus.size_err  = err_q;

endmodule

// File: tb/tb_fft_input_loader.sv
// Randomized bench for fft_input_loader: frames are checked against a lane model built from
// the accepted sample list; follows BIT_REVERSE_EN the same way the design does.
module tb_fft_input_loader;
  localparam int W  = 9;
  localparam int P  = 32;
  localparam int VW = W * P;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_input_loader_if #(.formatWidth(W), .POINTS(P)) bus ();

  fft_input_loader #(.formatWidth(W), .POINTS(P)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks  = 0;
  int n_pass    = 0;
  int start_cnt = 0;

  logic [W-1:0] exp_re [P];
  logic [W-1:0] exp_im [P];
  logic         exp_err;

  always @(negedge clk) if (bus.fft_start === 1'b1) start_cnt++;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] pack_re();
    logic [VW-1:0] v;
    for (int k = 0; k < P; k++) v[k*W +: W] = exp_re[k];
    return v;
  endfunction

  function automatic logic [VW-1:0] pack_im();
    logic [VW-1:0] v;
    for (int k = 0; k < P; k++) v[k*W +: W] = exp_im[k];
    return v;
  endfunction

  // Lane that the k-th sample of an n-sample frame should occupy.
  function automatic int exp_lane(input int k, input int n);
`ifdef BIT_REVERSE_EN
    int r = 0;
    int m = n;
    int kk = k;
    while (m > 1) begin
      r  = r * 2 + (kk % 2);
      kk = kk / 2;
      m  = m / 2;
    end
    return r;
`else
    return k % n;
`endif
  endfunction

  function automatic logic [W-1:0] lane_of(input logic [VW-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.fft_done = 1'b0;
    #1;
    check("rst_in_ready", VW'(bus.in_ready), '0);
    step();
    check("rst_fft_start", VW'(bus.fft_start), '0);
    check("rst_busy",      VW'(bus.busy),      '0);
    check("rst_size_err",  VW'(bus.size_err),  '0);
    check("rst_real",      bus.input_real,     '0);
    check("rst_imag",      bus.input_imag,     '0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", VW'(bus.in_ready), VW'(1));
    for (int k = 0; k < P; k++) begin
      exp_re[k] = '0;
      exp_im[k] = '0;
    end
    exp_err = 1'b0;
  endtask

  // mode 0: random samples, 1: real=k imag=0, 2: all 9'h1FF.
  task automatic send_frame(input int size, input int mode, input int gap_max, input int hold);
    logic [W-1:0] sr [P];
    logic [W-1:0] si [P];
    bit           legal;
    int           n;
    int           starts0;
    legal   = (size == 4) || (size == 8) || (size == 16) || (size == 32);
    n       = legal ? size : P;
    starts0 = start_cnt;
    if (!legal) exp_err = 1'b1;

    for (int k = 0; k < n; k++) begin
      if (k > 0 && gap_max > 0) begin
        int g = $urandom_range(gap_max, 0);
        repeat (g) begin
          bus.in_valid = 1'b0;
          bus.fft_done = 1'($urandom_range(1, 0));
          bus.fft_size = 11'($urandom);
          bus.in_real  = W'($urandom);
          check("gap_ready", VW'(bus.in_ready), VW'(1));
          step();
        end
      end
      case (mode)
        1:       begin sr[k] = W'(k);     si[k] = '0;         end
        2:       begin sr[k] = '1;        si[k] = '1;         end
        default: begin sr[k] = W'($urandom); si[k] = W'($urandom); end
      endcase
      if (k == 0) bus.fft_size = 11'(size);
      bus.fft_done = 1'($urandom_range(1, 0));
      bus.in_valid = 1'b1;
      bus.in_real  = sr[k];
      bus.in_imag  = si[k];
      check("hs_ready", VW'(bus.in_ready), VW'(1));
      step();
      if (k == n - 2) check("no_early_start", VW'(bus.fft_start), '0);
    end

    check("start_pulse",   VW'(bus.fft_start), VW'(1));
    check("start_ready",   VW'(bus.in_ready),  '0);
    check("start_busy",    VW'(bus.busy),      '0);

    for (int j = n; j < P; j++) begin
      exp_re[j] = '0;
      exp_im[j] = '0;
    end
    for (int k = 0; k < n; k++) begin
      exp_re[exp_lane(k, n)] = sr[k];
      exp_im[exp_lane(k, n)] = si[k];
    end

    bus.in_valid = 1'($urandom_range(1, 0));
    bus.fft_done = 1'($urandom_range(1, 0));
    bus.in_real  = W'($urandom);
    step();
    check("start_one_cycle", VW'(bus.fft_start), '0);
    check("busy_high",       VW'(bus.busy),      VW'(1));
    check("size_err",        VW'(bus.size_err),  VW'(exp_err));
    check("frame_real",      bus.input_real,     pack_re());
    check("frame_imag",      bus.input_imag,     pack_im());
    check("start_count",     VW'(start_cnt - starts0), VW'(1));

    repeat (hold) begin
      bus.in_valid = 1'b1;
      bus.fft_done = 1'b0;
      bus.in_real  = W'($urandom);
      bus.fft_size = 11'($urandom);
      check("busy_not_ready", VW'(bus.in_ready), '0);
      step();
    end
    check("busy_held",   VW'(bus.busy),  VW'(1));
    check("stable_real", bus.input_real, pack_re());
    check("stable_imag", bus.input_imag, pack_im());

    bus.fft_done = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_real  = W'($urandom);
    step();
    bus.fft_done = 1'b0;
    bus.in_valid = 1'b0;
    check("done_busy_low", VW'(bus.busy),     '0);
    check("done_ready",    VW'(bus.in_ready), VW'(1));
    check("done_no_take",  bus.input_real,    pack_re());
  endtask

  initial begin
    int sizes [11] = '{4, 8, 16, 32, 0, 1, 2, 12, 33, 64, 2047};
    logic [W-1:0] x;
    int s0;

    bus.fft_size = 11'd32;
    bus.in_valid = 1'b0;
    bus.in_real  = '0;
    bus.in_imag  = '0;
    bus.fft_done = 1'b0;
    rst          = 1'b1;
    step();
    do_reset();

    // Ramp frame of 32, back to back.
    send_frame(32, 1, 0, 3);
`ifdef BIT_REVERSE_EN
    check("rev_lane1",  VW'(lane_of(bus.input_real, 1)),  VW'(16));
    check("rev_lane2",  VW'(lane_of(bus.input_real, 2)),  VW'(8));
    check("rev_lane31", VW'(lane_of(bus.input_real, 31)), VW'(31));
`else
    check("nat_lane1",  VW'(lane_of(bus.input_real, 1)),  VW'(1));
    check("nat_lane2",  VW'(lane_of(bus.input_real, 2)),  VW'(2));
    check("nat_lane31", VW'(lane_of(bus.input_real, 31)), VW'(31));
`endif

    // Full frame of ones followed by a short frame: upper lanes must be cleared.
    send_frame(32, 2, 0, 2);
    send_frame(8, 0, 2, 2);
    check("upper_real_zero", bus.input_real >> (8 * W), '0);
    check("upper_imag_zero", bus.input_imag >> (8 * W), '0);

    // Ten busy cycles with in_valid held; the next sample lands in lane 0 right after done.
    send_frame(16, 0, 2, 10);
    x = W'($urandom);
    bus.in_valid = 1'b1;
    bus.in_real  = x;
    bus.in_imag  = '0;
    bus.fft_size = 11'd8;
    step();
    bus.in_valid = 1'b0;
    check("after_done_lane0", VW'(lane_of(bus.input_real, 0)), VW'(x));
    do_reset();

    for (int f = 0; f < 12; f++) begin
      send_frame(sizes[$urandom_range(10, 0)], 0, 3, $urandom_range(6, 1));
    end

    // Illegal size, then reset mid-fill: frame discarded with no start.
    do_reset();
    s0 = start_cnt;
    bus.fft_size = 11'd12;
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.in_real  = W'($urandom);
      bus.in_imag  = W'($urandom);
      step();
      if (k == 0) check("illegal_size_err", VW'(bus.size_err), VW'(1));
    end
    check("illegal_still_filling", VW'(bus.in_ready), VW'(1));
    do_reset();
    repeat (40) step();
    check("no_start_after_rst", VW'(start_cnt - s0), '0);
    check("idle_busy_low",      VW'(bus.busy),       '0);

    // Reset mid-busy: frame is gone, loader back in IDLE.
    send_frame(4, 0, 0, 1);
    bus.fft_size = 11'd4;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.in_real  = W'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("pre_rst_busy", VW'(bus.busy), VW'(1));
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fft_input_loader.md
FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 Parameter formatWidth, default 9, width in bits of one custom-float sample (1 sign, 4 exp, 4 sig).
REQ-002 Parameter POINTS, default 32, maximum FFT length and number of parallel lanes.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fft_size  input  11  requested frame length; sampled only in IDLE.
REQ-006 in_valid  input  1  upstream sample valid.
REQ-007 in_ready  output  1  loader can accept a sample this cycle.
REQ-008 in_real  input  formatWidth  real part of the incoming sample.
REQ-009 in_imag  input  formatWidth  imaginary part of the incoming sample.
REQ-010 input_real  output  formatWidth*POINTS  packed frame; lane k at bits [k*formatWidth +: formatWidth].
REQ-011 input_imag  output  formatWidth*POINTS  packed frame, same lane layout.
REQ-012 fft_start  output  1  one-cycle pulse to the FFT core.
REQ-013 fft_done  input  1  FFT core completion pulse.
REQ-014 busy  output  1  high from fft_start until fft_done accepted.
REQ-015 size_err  output  1  sticky flag: an illegal fft_size was latched.

Function
REQ-016 FSM states: IDLE, FILL, START, BUSY.
REQ-017 IDLE: in_ready=1; on a handshake (in_valid&in_ready), latch the frame length N, write the sample to lane 0, set count=1, go to FILL; if N==1, go to START.
REQ-018 Legal N: 4, 8, 16, 32. Any other value latches N=POINTS and sets size_err.
REQ-019 On the transition from IDLE into FILL, lanes N..POINTS-1 are cleared to zero.
REQ-020 FILL: in_ready=1; each handshake writes lane addr(count) and increments count; the handshake with count==N-1 moves to START.
REQ-021 Without in_valid, count and the lanes hold; gaps of any length are allowed.
REQ-022 START: in_ready=0, fft_start=1 for exactly one cycle, then BUSY.
REQ-023 BUSY: in_ready=0, busy=1; fft_done moves to IDLE; the next sample can be accepted the cycle after fft_done.
REQ-024 fft_done is ignored in IDLE, FILL and START.
REQ-025 input_real/input_imag are stable from START until fft_done is accepted.
REQ-026 Latency: fft_start is asserted the cycle after the N-th handshake.
REQ-027 fft_size changes outside IDLE have no effect on the current frame.

Reset
REQ-028 On rst=1 at a clock edge: state=IDLE, count=0, all lanes=0, fft_start=0, busy=0, size_err=0, in_ready=0 during the reset cycle.
REQ-029 rst mid-FILL or mid-BUSY discards the frame; no fft_start is issued for it.

Configuration
REQ-030 Macro BIT_REVERSE_EN: when defined, addr(count) is count bit-reversed over log2(N) bits (natural-order input, bit-reversed lanes).
REQ-031 When BIT_REVERSE_EN is undefined, addr(count)=count.

Verification
REQ-032 fft_size=32, samples real=k, imag=0 for k=0..31, no gaps, macro off -> lane k real=k; fft_start pulses once, 1 cycle after the 32nd handshake; busy=1.
REQ-033 Same stimulus with BIT_REVERSE_EN defined -> lane 1 holds 16, lane 2 holds 8, lane 31 holds 31.
REQ-034 fft_size=8, prior frame all 9'h1FF -> lanes 8..31 are 0; fft_start after the 8th handshake.
REQ-035 During BUSY, in_valid=1 held, fft_done pulsed after 10 cycles -> no sample accepted while busy; next sample lands in lane 0 the cycle after fft_done.
REQ-036 fft_size=12 -> size_err=1, frame length 32; rst asserted after 5 samples -> all outputs 0, no fft_start, size_err=0.
